// File: rtl/spi_pkg.sv
// Constants shared by the SPI master, the SPI slave and the receive-side buffer.
package spi_pkg;
  localparam int DATA_W        = 12;
  localparam int RX_FIFO_DEPTH = 8;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for single-bit SPI-domain signals (done, cs, ...).
// Latency 2 clk; no flow control.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive FIFO for SPI frames: one push per rising edge of done, written 3 clk after done is sampled.
// First-word fall-through read side; a push into a full FIFO without a pop is dropped and flagged.
module spi_rx_buffer #(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int DEPTH  = spi_pkg::RX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  import spi_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic done_s;
  logic done_d;
  logic sync_ready;
  logic armed;
  logic push;
  logic do_push;
  logic do_pop;
  logic drop;

  sync_2ff u_sync_done (
    .clk (clk),
    .rst (rst),
    .d   (done),
    .q   (done_s)
  );

  // Goes high once done_s carries a real post-reset sample; lets a done level
  // held across reset be ignored until it has been seen low.
  sync_2ff u_sync_ready (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (sync_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      done_d <= done_s;
      armed  <= armed | (sync_ready & ~done_s);
    end
  end

  assign push    = done_s & ~done_d & armed;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop wins over a clear arriving in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed bench for spi_rx_buffer with a queue-based reference model checked every cycle.
module tb_spi_rx_buffer;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              done = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              pop = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [3:0]        count;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  spi_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .rx_data  (rx_data),
    .pop      (pop),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue; run = consecutive high samples
  // of done since the last low sample, -1 while no low sample seen since reset.
  logic [DATA_W-1:0] q[$];
  bit m_ovf = 1'b0;
  int run = -1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      run   = -1;
    end else begin
      bit push_ev;
      bit pop_ok;
      bit dropped;
      push_ev = (run == 2);
      pop_ok  = pop && (q.size() > 0);
      dropped = 1'b0;
      if (pop_ok) void'(q.pop_front());
      if (push_ev) begin
        if (q.size() < DEPTH) q.push_back(rx_data);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (!done) run = 0;
      else if (run >= 0) run = run + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int n;
      n = q.size();
      chk("count",    int'(count),    n);
      chk("empty",    int'(empty),    int'(n == 0));
      chk("full",     int'(full),     int'(n == DEPTH));
      chk("rd_valid", int'(rd_valid), int'(n != 0));
      chk("rd_data",  int'(rd_data),  (n != 0) ? int'(q[0]) : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [DATA_W-1:0] d, input int hi, input int lo);
    rx_data = d;
    done    = 1'b1;
    tick(hi);
    done    = 1'b0;
    tick(lo);
  endtask

  task automatic pop1;
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  task automatic pop_expect(input logic [DATA_W-1:0] d, input string name);
    chk(name, int'(rd_data), int'(d));
    pop1();
  endtask

  logic [DATA_W-1:0] fill_vals [8] = '{12'h001, 12'h002, 12'h003, 12'h004,
                                       12'h005, 12'h006, 12'h007, 12'h008};

  initial begin
    tick(3);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data",  int'(rd_data), 0);
    chk("rst_ovf",   int'(overflow), 0);
    rst = 1'b1;
    tick(2);
    cmp_en = 1'b1;

    // Single long frame: exactly one push, on the 3rd edge.
    rx_data = 12'hA5C;
    done    = 1'b1;
    tick(2);
    chk("lat_count_before", int'(count), 0);
    tick(1);
    chk("lat_count", int'(count), 1);
    chk("lat_data",  int'(rd_data), 12'hA5C);
    chk("lat_valid", int'(rd_valid), 1);
    tick(19);
    done = 1'b0;
    tick(4);
    chk("single_push", int'(count), 1);
    pop_expect(12'hA5C, "single_pop");

    // Fill to full.
    foreach (fill_vals[i]) frame(fill_vals[i], 4, 3);
    chk("fill_full",  int'(full), 1);
    chk("fill_count", int'(count), 8);

    // Drop while full, then clear.
    frame(12'hFFF, 4, 3);
    chk("ovf_set",  int'(overflow), 1);
    chk("ovf_head", int'(rd_data), 12'h001);
    chk("ovf_count", int'(count), 8);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    // Drop and clear in the same cycle: flag stays set.
    rx_data = 12'hEEE;
    done    = 1'b1;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_clr_race", int'(overflow), 1);
    tick(1);
    done = 1'b0;
    tick(3);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;

    // Full with simultaneous push and pop.
    rx_data = 12'h123;
    done    = 1'b1;
    tick(2);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    chk("fullpp_count", int'(count), 8);
    chk("fullpp_ovf",   int'(overflow), 0);
    chk("fullpp_head",  int'(rd_data), 12'h002);
    tick(1);
    done = 1'b0;
    tick(3);
    for (int i = 1; i < 8; i++) pop_expect(fill_vals[i], "drain_order");
    pop_expect(12'h123, "drain_last");
    chk("drain_empty", int'(empty), 1);
    chk("drain_data",  int'(rd_data), 0);

    // Pop on empty is ignored; push+pop on empty yields one entry.
    pop1();
    chk("empty_pop", int'(count), 0);
    rx_data = 12'h3C3;
    done    = 1'b1;
    tick(2);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    chk("emptypp_count", int'(count), 1);
    chk("emptypp_data",  int'(rd_data), 12'h3C3);
    tick(1);
    done = 1'b0;
    tick(3);
    pop1();

    // 20 frames interleaved with pops across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      frame(DATA_W'(12'h200 + i), 4, 3);
      if (i % 3 != 0) pop1();
    end
    while (!empty) pop1();
    pop1();
    chk("wrap_empty", int'(empty), 1);

    // Reset mid-operation with done held high.
    for (int i = 0; i < 5; i++) frame(DATA_W'(12'h050 + i), 4, 3);
    chk("pre_rst_count", int'(count), 5);
    rx_data = 12'h666;
    done    = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("rst_async_count", int'(count), 0);
    chk("rst_async_empty", int'(empty), 1);
    tick(2);
    rst = 1'b1;
    tick(10);
    chk("rst_no_push", int'(count), 0);
    done = 1'b0;
    tick(3);
    frame(12'h777, 4, 3);
    chk("rst_repush_count", int'(count), 1);
    chk("rst_repush_data",  int'(rd_data), 12'h777);
    pop1();
    tick(2);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
